// File: rtl/pic_ram_writer.sv
// Captures one frame of a vsync/de/RGB pixel stream and writes it raster-order
// into a single-port RAM, address 0 = pixel (0,0), one cycle of write latency.
module pic_ram_writer #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned IMG_W      = 256,
  parameter int unsigned IMG_H      = 256,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_vs,
  input  logic                  in_de,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_short
);

  localparam int unsigned X_W  = $clog2(IMG_W + 1);
  localparam int unsigned Y_W  = $clog2(IMG_H + 1);
  localparam int unsigned LB_W = $clog2(IMG_W * IMG_H + 1);
  localparam int unsigned S_W  = LB_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_vs_d, r_de_d;
  logic [X_W-1:0]        r_x, w_x_nxt;
  logic [Y_W-1:0]        r_y, w_y_nxt;
  logic [LB_W-1:0]       r_line_base, w_line_base_nxt;
  logic                  r_wr_en, r_busy, r_frame_done, r_err_short;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data;
  logic                  w_wr_en, w_busy, w_frame_done, w_err_short;

  logic                  w_vs_rise, w_de_fall, w_in_win, w_pix_ok, w_last;
  logic [S_W-1:0]        w_addr_sum;

  assign w_vs_rise  = in_vs & ~r_vs_d;
  assign w_de_fall  = r_de_d & ~in_de;
  assign w_in_win   = (r_x < X_W'(IMG_W)) && (r_y < Y_W'(IMG_H));
  assign w_pix_ok   = (r_state == S_CAPTURE) && in_de && !w_vs_rise && w_in_win;
  assign w_last     = w_pix_ok && (r_x == X_W'(IMG_W - 1)) && (r_y == Y_W'(IMG_H - 1));
  assign w_addr_sum = S_W'(r_line_base) + S_W'(r_x);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_vs_d       <= 1'b0;
      r_de_d       <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_line_base  <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_short  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_vs_d       <= in_vs;
      r_de_d       <= in_de;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_line_base  <= w_line_base_nxt;
      r_wr_en      <= w_wr_en;
      r_wr_addr    <= w_wr_addr;
      r_wr_data    <= w_wr_data;
      r_busy       <= w_busy;
      r_frame_done <= w_frame_done;
      r_err_short  <= w_err_short;
    end
  end

  // Next state and raster counters; vs_rise outranks pixels and line ends
  always_comb begin
    w_state_nxt     = r_state;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_line_base_nxt = r_line_base;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        if (w_vs_rise) begin
          w_state_nxt     = S_CAPTURE;
          w_x_nxt         = '0;
          w_y_nxt         = '0;
          w_line_base_nxt = '0;
        end
      end
      S_CAPTURE: begin
        if (w_vs_rise) begin
          w_x_nxt         = '0;
          w_y_nxt         = '0;
          w_line_base_nxt = '0;
        end else if (w_pix_ok) begin
          w_x_nxt = r_x + X_W'(1);
          if (w_last) w_state_nxt = S_DONE;
        end else if (w_de_fall && (r_y < Y_W'(IMG_H))) begin
          w_x_nxt         = '0;
          w_y_nxt         = r_y + Y_W'(1);
          w_line_base_nxt = r_line_base + LB_W'(IMG_W);
        end
      end
      S_DONE: begin
        w_state_nxt = CONTINUOUS ? S_ARM : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output values, registered one cycle later
  always_comb begin
    w_wr_en      = w_pix_ok;
    w_wr_addr    = r_wr_addr;
    w_wr_data    = r_wr_data;
    w_busy       = (w_state_nxt == S_ARM) || (w_state_nxt == S_CAPTURE);
    w_frame_done = (r_state == S_DONE);
    w_err_short  = (r_state == S_CAPTURE) && w_vs_rise;
    if (w_pix_ok) begin
      w_wr_addr = ADDR_WIDTH'(w_addr_sum);
      w_wr_data = in_data;
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign err_short  = r_err_short;

endmodule

// File: tb/tb_pic_ram_writer.sv
// Directed bench for pic_ram_writer on a 4x2 image: vector table for single-frame
// scenarios, plus a hand-written continuous-mode sequence on a second instance.
module tb_pic_ram_writer;

  logic        clk, rst, start, in_vs, in_de;
  logic [23:0] in_data;

  logic        wr_en, busy, frame_done, err_short;
  logic [15:0] wr_addr;
  logic [23:0] wr_data;
  logic        c_wr_en, c_busy, c_frame_done, c_err_short;
  logic [15:0] c_wr_addr;
  logic [23:0] c_wr_data;

  int n_total = 0;
  int n_bad   = 0;
  int c_done  = 0;
  int c_writes = 0;
  int cur_tid = 0;

  pic_ram_writer #(.ADDR_WIDTH(16), .DATA_WIDTH(24), .IMG_W(4), .IMG_H(2), .CONTINUOUS(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .err_short(err_short));

  pic_ram_writer #(.ADDR_WIDTH(16), .DATA_WIDTH(24), .IMG_W(4), .IMG_H(2), .CONTINUOUS(1'b1)) u_dut_c (
    .clk(clk), .rst(rst), .start(start), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .busy(c_busy),
    .frame_done(c_frame_done), .err_short(c_err_short));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  typedef struct {
    logic        rst, start, vs, de;
    logic [23:0] data;
    logic        we, ck;
    logic [15:0] addr;
    logic [23:0] wd;
    logic        done, err, busy;
    int          tid;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, s, vs, de, input logic [23:0] d,
                     input logic we, ck, input logic [15:0] a, input logic [23:0] wd,
                     input logic dn, er, bz);
    vec_t v;
    v.rst = r; v.start = s; v.vs = vs; v.de = de; v.data = d;
    v.we = we; v.ck = ck; v.addr = a; v.wd = wd;
    v.done = dn; v.err = er; v.busy = bz; v.tid = cur_tid;
    vq.push_back(v);
  endtask

  task automatic rstv();
    add(1, 0, 0, 0, 24'h0, 0, 1, 16'h0, 24'h0, 0, 0, 0);
  endtask

  // Pixel in CAPTURE that must be written to address a
  task automatic pix(input logic [23:0] d, input logic [15:0] a);
    add(0, 0, 0, 1, d, 1, 1, a, d, 0, 0, 1);
  endtask

  task automatic cstep(input logic s, vs, de, input logic [23:0] d,
                       input logic ew, input logic [15:0] ea);
    @(negedge clk);
    rst = 1'b0; start = s; in_vs = vs; in_de = de; in_data = d;
    @(posedge clk);
    #1;
    if (c_frame_done) c_done++;
    if (c_wr_en) c_writes++;
    n_total++;
    if (c_wr_en !== ew || (ew && (c_wr_addr !== ea || c_wr_data !== d))) begin
      n_bad++;
      $display("FAIL cont_write: got we=%b addr=%0d data=%h, want we=%b addr=%0d data=%h",
               c_wr_en, c_wr_addr, c_wr_data, ew, ea, d);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_vs = 1'b0; in_de = 1'b0; in_data = '0;

    // 1: normal capture, then DONE and a stray pixel in IDLE
    cur_tid = 1;
    rstv();
    add(0, 1, 0, 0, 24'h0, 0, 0, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 1, 0, 24'h0, 0, 0, 16'h0, 24'h0, 0, 0, 1);
    for (int i = 0; i < 4; i++) pix(24'(i + 1), 16'(i));
    add(0, 0, 0, 0, 24'h0, 0, 0, 16'h0, 24'h0, 0, 0, 1);
    for (int i = 0; i < 3; i++) pix(24'(i + 5), 16'(i + 4));
    add(0, 0, 0, 1, 24'h8, 1, 1, 16'h7, 24'h8, 0, 0, 0);
    add(0, 0, 0, 0, 24'h0, 0, 1, 16'h7, 24'h8, 1, 0, 0);
    add(0, 0, 0, 1, 24'h9, 0, 1, 16'h7, 24'h8, 0, 0, 0);

    // 2: cropped line, short line, early vsync restarts at address 0
    cur_tid = 2;
    rstv();
    add(0, 1, 0, 0, 24'h0, 0, 0, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 1, 0, 24'h0, 0, 0, 16'h0, 24'h0, 0, 0, 1);
    for (int i = 0; i < 4; i++) pix(24'(32'hA0 + i), 16'(i));
    add(0, 0, 0, 1, 24'hA4, 0, 1, 16'h3, 24'hA3, 0, 0, 1);
    add(0, 0, 0, 1, 24'hA5, 0, 1, 16'h3, 24'hA3, 0, 0, 1);
    add(0, 0, 0, 0, 24'h0, 0, 0, 16'h0, 24'h0, 0, 0, 1);
    for (int i = 0; i < 3; i++) pix(24'(32'hB0 + i), 16'(i + 4));
    add(0, 0, 0, 0, 24'h0, 0, 0, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 1, 0, 24'h0, 0, 1, 16'h6, 24'hB2, 0, 1, 1);
    add(0, 0, 1, 1, 24'hC0, 1, 1, 16'h0, 24'hC0, 0, 0, 1);

    // 3: pixels in IDLE, ARM and on the vsync edge are dropped
    cur_tid = 3;
    rstv();
    add(0, 0, 0, 1, 24'h11, 0, 1, 16'h0, 24'h0, 0, 0, 0);
    add(0, 1, 0, 1, 24'h12, 0, 1, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 0, 1, 24'h22, 0, 1, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 1, 1, 24'h33, 0, 1, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 1, 1, 24'h44, 1, 1, 16'h0, 24'h44, 0, 0, 1);
    add(0, 0, 1, 1, 24'h45, 1, 1, 16'h1, 24'h45, 0, 0, 1);
    rstv();
    add(0, 1, 1, 0, 24'h0, 0, 1, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 1, 1, 24'h55, 0, 1, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 0, 0, 24'h0, 0, 0, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 1, 0, 24'h0, 0, 0, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 1, 1, 24'h66, 1, 1, 16'h0, 24'h66, 0, 0, 1);

    // 5: reset mid-frame clears outputs; writes resume only after start and a new edge
    cur_tid = 5;
    rstv();
    add(0, 1, 0, 0, 24'h0, 0, 0, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 1, 0, 24'h0, 0, 0, 16'h0, 24'h0, 0, 0, 1);
    for (int i = 0; i < 3; i++) pix(24'(i + 1), 16'(i));
    add(1, 0, 0, 1, 24'h4, 0, 1, 16'h0, 24'h0, 0, 0, 0);
    add(0, 0, 0, 1, 24'h5, 0, 1, 16'h0, 24'h0, 0, 0, 0);
    add(0, 0, 1, 1, 24'h6, 0, 1, 16'h0, 24'h0, 0, 0, 0);
    add(0, 0, 1, 0, 24'h0, 0, 1, 16'h0, 24'h0, 0, 0, 0);
    add(0, 1, 1, 0, 24'h0, 0, 1, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 1, 1, 24'h7, 0, 1, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 0, 0, 24'h0, 0, 1, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 1, 0, 24'h0, 0, 1, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 0, 1, 24'h8, 1, 1, 16'h0, 24'h8, 0, 0, 1);

    // 6: start while capturing is ignored
    cur_tid = 6;
    rstv();
    add(0, 1, 0, 0, 24'h0, 0, 0, 16'h0, 24'h0, 0, 0, 1);
    add(0, 0, 1, 0, 24'h0, 0, 0, 16'h0, 24'h0, 0, 0, 1);
    pix(24'h1, 16'h0);
    pix(24'h2, 16'h1);
    add(0, 1, 0, 1, 24'h3, 1, 1, 16'h2, 24'h3, 0, 0, 1);
    pix(24'h4, 16'h3);
    add(0, 0, 0, 0, 24'h0, 0, 0, 16'h0, 24'h0, 0, 0, 1);
    for (int i = 0; i < 3; i++) pix(24'(i + 5), 16'(i + 4));
    add(0, 0, 0, 1, 24'h8, 1, 1, 16'h7, 24'h8, 0, 0, 0);
    add(0, 0, 0, 0, 24'h0, 0, 0, 16'h0, 24'h0, 1, 0, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; start = vq[i].start; in_vs = vq[i].vs;
      in_de = vq[i].de; in_data = vq[i].data;
      @(posedge clk);
      #1;
      n_total++;
      if (wr_en !== vq[i].we || frame_done !== vq[i].done || err_short !== vq[i].err ||
          busy !== vq[i].busy ||
          (vq[i].ck && (wr_addr !== vq[i].addr || wr_data !== vq[i].wd))) begin
        n_bad++;
        $display("FAIL vec t%0d #%0d: got we=%b addr=%h data=%h done=%b err=%b busy=%b, want we=%b addr=%h data=%h done=%b err=%b busy=%b",
                 vq[i].tid, i, wr_en, wr_addr, wr_data, frame_done, err_short, busy,
                 vq[i].we, vq[i].addr, vq[i].wd, vq[i].done, vq[i].err, vq[i].busy);
      end
    end

    // 4: continuous mode, two frames after a single start, extra lines ignored
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_vs = 1'b0; in_de = 1'b0; in_data = '0;
    @(posedge clk);
    #1;
    cstep(1, 0, 0, 24'h0, 0, 16'h0);
    cstep(0, 1, 0, 24'h0, 0, 16'h0);
    for (int f = 0; f < 2; f++) begin
      if (f == 1) cstep(0, 1, 0, 24'h0, 0, 16'h0);
      for (int l = 0; l < 2; l++) begin
        for (int p = 0; p < 4; p++)
          cstep(0, 0, 1, 24'(f * 16 + l * 4 + p + 1), 1, 16'(l * 4 + p));
        cstep(0, 0, 0, 24'h0, 0, 16'h0);
      end
      n_total++;
      if (c_busy !== 1'b1 || c_done != f + 1) begin
        n_bad++;
        $display("FAIL cont_rearm f%0d: got busy=%b done_count=%0d, want busy=1 done_count=%0d",
                 f, c_busy, c_done, f + 1);
      end
      for (int p = 0; p < 4; p++) cstep(0, 0, 1, 24'(32'hE0 + p), 0, 16'h0);
      cstep(0, 0, 0, 24'h0, 0, 16'h0);
    end
    n_total++;
    if (c_done != 2 || c_writes != 16) begin
      n_bad++;
      $display("FAIL cont_totals: got done=%0d writes=%0d, want done=2 writes=16", c_done, c_writes);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pic_ram_writer.md
Name: pic_ram_writer

Overview:
Write-side counterpart to the picture ROM used by the HDMI picture/Gaussian-filter demo. It captures one frame from a video-style pixel stream (vsync, data-enable, 24-bit RGB), for example the Gaussian filter output. It writes the frame raster-order into a single-port 2^ADDR_WIDTH x DATA_WIDTH block RAM. Address 0 holds pixel (0,0), so a reader can later fetch the frame with the same addressing as the ROM.

Parameters:
ADDR_WIDTH, 16, RAM address width; requires IMG_W*IMG_H <= 2^ADDR_WIDTH
DATA_WIDTH, 24, pixel/RAM word width (RGB888)
IMG_W, 256, pixels per stored line; pixels beyond this count in a line are cropped
IMG_H, 256, lines per stored frame; lines beyond this count are ignored
CONTINUOUS, 0, 0 = one frame per start pulse; 1 = re-arm automatically after every frame

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle capture request; ignored unless state is IDLE
in_vs  input  1  frame sync, active high; a rising edge marks frame start
in_de  input  1  pixel valid / line active
in_data  input  DATA_WIDTH  pixel value, qualified by in_de
wr_en  output  1  RAM write enable
wr_addr  output  ADDR_WIDTH  RAM write address
wr_data  output  DATA_WIDTH  RAM write data
busy  output  1  high in ARM and CAPTURE
frame_done  output  1  one-cycle pulse when a full frame has been stored
err_short  output  1  one-cycle pulse when a frame is aborted by an early vsync

Behaviour:
- Reset: synchronous. State goes to IDLE. wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, err_short=0. x, y, line_base and vs_d are all cleared. A reset asserted mid-capture abandons the frame with no further writes; the partial RAM contents are left as they are.
- vs_rise = in_vs & ~vs_d, where vs_d is in_vs registered once.
- States:
  - IDLE: start=1 -> ARM.
  - ARM: vs_rise -> CAPTURE, with x=0, y=0, line_base=0.
  - CAPTURE: stores pixels, see below.
  - DONE: lasts one cycle. frame_done=1. Next state is ARM if CONTINUOUS=1, otherwise IDLE.
- CAPTURE pixel rule. When in_de=1 and no vs_rise occurs in that cycle:
  - If x<IMG_W and y<IMG_H: next cycle wr_en=1, wr_addr=line_base+x, wr_data=in_data, and x increments.
  - Otherwise: no write.
  - Write latency is exactly 1 cycle from input to the wr_* outputs. Every output is registered.
- Line advance: a falling edge of in_de (de_d=1, in_de=0) sets x=0, y=y+1 and line_base=line_base+IMG_W.
  - A short line leaves its unwritten addresses untouched.
  - Cropped pixels never wrap into the next line.
- Frame complete: the cycle that issues the write with y=IMG_H-1 and x=IMG_W-1 transitions to DONE. frame_done is therefore high in the cycle after that final wr_en pulse.
  - Any in_de after completion is ignored. This includes in CONTINUOUS mode until the next vs_rise in ARM.
- Early vsync: a vs_rise in CAPTURE before completion does the following.
  - Pulses err_short in the next cycle.
  - Restarts capture of the new frame: x=0, y=0, line_base=0, and the state stays CAPTURE.
  - Any pixel in the vs_rise cycle is discarded. This also applies in ARM.
- Simultaneous events: vs_rise takes priority over the de falling edge and over pixel writes. start outside IDLE is ignored. start and vs_rise in the same cycle in IDLE -> ARM only; that edge is not used, so capture waits for the next vs_rise.
- wr_en is low in every state except for qualifying CAPTURE writes. wr_addr and wr_data hold their last values when wr_en=0.
- busy = state is ARM or CAPTURE, registered.
- Arithmetic: x, y and line_base are unsigned counters wide enough for IMG_W, IMG_H and IMG_W*IMG_H. wr_addr is the truncation of line_base+x to ADDR_WIDTH. With legal parameters no overflow is possible.

Test Plan:
Bench parameters for all scenarios: IMG_W=4, IMG_H=2, CONTINUOUS=0.
1. Normal capture. Pulse start, then vs_rise, then 2 lines of 4 pixels with data 0x000001..0x000008. Required: 8 wr_en pulses with addr 0..7 and data 1..8, each 1 cycle after in_de. frame_done pulses the cycle after the addr-7 write. busy returns to 0.
2. Crop and short line. Line 0 has 6 pixels (A..F), line 1 has 3 pixels (G,H,I), then the next frame begins. Required: writes addr0..3 = A..D and addr4..6 = G..I. E and F are not written. No frame_done. err_short pulses on the next vs_rise, and capture restarts at addr 0.
3. Ignored inputs. Pixels in IDLE, pixels in ARM before vsync, and a pixel coincident with vs_rise. Required: no wr_en pulses. The first write after vs_rise is addr 0 carrying the pixel after the edge.
4. Continuous mode. Set CONTINUOUS=1 and send 2 back-to-back full frames after one start. Required: 16 writes, addr 0..7 twice, and two frame_done pulses. The state is ARM after each frame. Extra in_de lines after completion produce no writes.
5. Reset mid-frame. Assert rst after the write to addr 2. Required: the cycle after rst, wr_en=0, busy=0 and all outputs are 0. Subsequent stream activity produces no writes until start and a new vs_rise.
6. Start during busy. Pulse start in CAPTURE. Required: no effect, and the addresses continue monotonically.
